// File: rtl/gate_tt_checker.sv
`default_nettype none
// ============================================================================
// Module : gate_tt_checker
// Drives the four input vectors of a 2-input gate and checks its output
// against the selected truth table, reporting per-vector failures.
// Rev    : 1.0  initial release
// ============================================================================
module gate_tt_checker #(
  parameter int SETTLE = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [1:0] op_sel,
  input  logic       dut_c,
  output logic       a,
  output logic       b,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic [3:0] fail_vec
);

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] op_q, op_d;
  logic [1:0] idx_q, idx_d;
  logic [3:0] cnt_q, cnt_d;
  logic       a_q, a_d;
  logic       b_q, b_d;
  logic       pass_q, pass_d;
  logic [2:0] err_q, err_d;
  logic [3:0] fail_q, fail_d;

  logic       expected;
  logic       mismatch;
  logic [2:0] err_inc;
  logic [3:0] fail_inc;

  always_comb begin
    expected = 1'b0;
    case (op_q)
      2'b00:   expected = a_q & b_q;
      2'b01:   expected = a_q | b_q;
      2'b10:   expected = a_q ^ b_q;
      default: expected = ~(a_q & b_q);
    endcase
  end

  assign mismatch = (dut_c != expected);
  assign err_inc  = err_q + 3'(mismatch);
  assign fail_inc = fail_q | (4'(mismatch) << idx_q);

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    pass_d  = pass_q;
    err_d   = err_q;
    fail_d  = fail_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          op_d    = op_sel;
          idx_d   = 2'd0;
          cnt_d   = 4'd0;
          a_d     = 1'b0;
          b_d     = 1'b0;
          pass_d  = 1'b0;
          err_d   = 3'd0;
          fail_d  = 4'd0;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == SETTLE_LAST) begin
          state_d = ST_SAMPLE;
        end
      end
      ST_SAMPLE: begin
        err_d  = err_inc;
        fail_d = fail_inc;
        // pass is resolved here so it is already valid while done is high
        if (idx_q == 2'd3) begin
          pass_d  = (err_inc == 3'd0);
          state_d = ST_DONE;
        end else begin
          idx_d   = idx_q + 2'd1;
          a_d     = idx_d[0];
          b_d     = idx_d[1];
          cnt_d   = 4'd0;
          state_d = ST_WAIT;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      op_q    <= 2'd0;
      idx_q   <= 2'd0;
      cnt_q   <= 4'd0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= 3'd0;
      fail_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      fail_q  <= fail_d;
    end
  end

  assign a         = a_q;
  assign b         = b_q;
  assign busy      = (state_q == ST_WAIT) || (state_q == ST_SAMPLE);
  assign done      = (state_q == ST_DONE);
  assign pass      = pass_q;
  assign err_count = err_q;
  assign fail_vec  = fail_q;

endmodule
`default_nettype wire

// File: doc/gate_tt_checker.md
GATE_TT_CHECKER -- requirements
Module: gate_tt_checker

Interface
REQ-001 Parameter SETTLE, default 2, legal range 1..15: wait cycles between driving a vector and sampling dut_c.
REQ-002 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-003 clk  in  1  rising-edge clock for all state.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 start  in  1  run request, sampled on a clk edge while idle.
REQ-006 op_sel  in  2  expected gate function: 00 AND, 01 OR, 10 XOR, 11 NAND.
REQ-007 dut_c  in  1  output of the 2-input gate under test.
REQ-008 a  out  1  registered gate input a.
REQ-009 b  out  1  registered gate input b.
REQ-010 busy  out  1  high while a run is in progress.
REQ-011 done  out  1  one-cycle pulse at end of run.
REQ-012 pass  out  1  result of last completed run: 1 means no mismatches.
REQ-013 err_count  out  3  mismatches in current or last run, 0..4.
REQ-014 fail_vec  out  4  bit i set when vector index i mismatched.

Function
REQ-015 States SHALL be: IDLE, WAIT, SAMPLE, DONE.
REQ-016 Vector index idx (2 bits) SHALL map as a=idx[0], b=idx[1], giving the order 00, 10, 01, 11 for (a,b).
REQ-017 IDLE, start=1: latch op_sel, idx=0, a=0, b=0, settle counter=0, err_count=0, fail_vec=0, pass=0; go to WAIT.
REQ-018 IDLE, start=0: hold all outputs.
REQ-019 WAIT: increment the settle counter each cycle; go to SAMPLE on the edge where the counter equals SETTLE-1.
REQ-020 SAMPLE: compare dut_c with expected f(op_sel_latched, a, b).
REQ-021 SAMPLE on mismatch: err_count+1 and fail_vec[idx]=1, in the same edge.
REQ-022 SAMPLE with idx<3: idx+1, a/b update from the new idx, counter=0, go to WAIT.
REQ-023 SAMPLE with idx=3: go to DONE; a/b hold at 1/1.
REQ-024 DONE: done=1 for exactly one cycle; pass = (final err_count==0); go to IDLE.
REQ-025 pass, err_count and fail_vec SHALL hold their values until the next accepted start.
REQ-026 busy SHALL be 1 in WAIT and SAMPLE and 0 in IDLE and DONE.
REQ-027 start SHALL be ignored outside IDLE, and op_sel changes mid-run SHALL have no effect.
REQ-028 Latency: done SHALL be high in the cycle following edge 4*(SETTLE+1), counted from the edge that accepted start.
REQ-029 a and b SHALL be stable for SETTLE+1 consecutive cycles per vector, with no glitch between vectors.
REQ-030 start held high continuously SHALL begin a new run on the edge after DONE (IDLE accepts it).
REQ-031 err_count SHALL NOT wrap, because the maximum value is 4.

Reset
REQ-032 rst_n=0 SHALL immediately force:
- state=IDLE
- a=0, b=0
- busy=0, done=0, pass=0
- err_count=0, fail_vec=0
- idx=0, counter=0
REQ-033 rst_n asserted mid-run SHALL abort the run with no done pulse; the first edge after deassertion is in IDLE.

Verification
REQ-034 SETTLE=2, op_sel=00, correct AND gate, start pulse -> a/b sequence 00,10,01,11; done after edge 12; pass=1, err_count=0, fail_vec=0000.
REQ-035 op_sel=00, dut_c stuck at 0 -> err_count=1, fail_vec=1000, pass=0.
REQ-036 op_sel=10 (XOR) against an AND gate -> err_count=3, fail_vec=1110, pass=0.
REQ-037 rst_n pulsed low during vector idx=2 -> all outputs 0 asynchronously; no done pulse; a new start gives a normal run.
REQ-038 start pulsed while busy, plus op_sel toggled mid-run -> no restart; results reflect the op_sel latched at start.
REQ-039 SETTLE=1, op_sel=11 against a NAND gate -> done after edge 8, pass=1.
